// File: rtl/lemming_dig_scheduler_pkg.sv
// Shared types and helpers for the lemming dig scheduler.
// Holds the FSM state encoding and the round-robin picker.
package lemming_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        WAIT,
        DIGGING
    } dig_state_e;

    localparam int SPLAT_LIMIT_DEF = 20;
    localparam int MAX_N           = 16;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } rr_pick_t;

    // First set bit of eligible at or after ptr, wrapping modulo n.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_N-1:0] eligible,
        input logic [3:0]       ptr,
        input int               n
    );
        rr_pick_t r;
        int       idx;
        r = '0;
        for (int k = 0; k < MAX_N; k++) begin
            if (k < n && !r.valid) begin
                idx = (int'(ptr) + k) % n;
                if (eligible[idx]) begin
                    r.valid = 1'b1;
                    r.idx   = 4'(idx);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lemming_dig_scheduler_if.sv
// Bundle between the command decode, the walker FSMs and the scheduler.
// master drives requests and walker status; slave is the scheduler.
interface lemming_dig_scheduler_if #(
    parameter int N          = 4,
    parameter int DIG_BUDGET = 8
);
    logic [N-1:0]                       req;
    logic                               refill;
    logic [N-1:0]                       walking;
    logic [N-1:0]                       digging;
    logic [N-1:0]                       aaah;
    logic [N-1:0]                       dig;
    logic [$clog2(N)-1:0]               owner;
    logic                               busy;
    logic [$clog2(DIG_BUDGET+1)-1:0]    tokens;
    logic [N-1:0]                       splat;

    modport master (
        output req, refill, walking, digging, aaah,
        input  dig, owner, busy, tokens, splat
    );

    modport slave (
        input  req, refill, walking, digging, aaah,
        output dig, owner, busy, tokens, splat
    );
endinterface

// File: rtl/lemming_dig_scheduler_fall_monitor.sv
// Per-lemming fall timer with a sticky splat flag.
// A fall longer than SPLAT_LIMIT cycles marks the lemming dead.
module lemming_fall_monitor
    import lemming_ctrl_pkg::*;
#(
    parameter int SPLAT_LIMIT = SPLAT_LIMIT_DEF
) (
    input  logic clk,
    input  logic areset_n,
    input  logic aaah,
    output logic splat
);
    localparam int CW = $clog2(SPLAT_LIMIT + 2);
    localparam logic [CW-1:0] SAT = CW'(SPLAT_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(SPLAT_LIMIT);

    logic [CW-1:0] r_cnt;
    logic          r_splat;

    // Count while falling; on landing judge the fall and clear.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_cnt   <= '0;
            r_splat <= 1'b0;
        end else if (aaah) begin
            if (r_cnt != SAT) r_cnt <= r_cnt + CW'(1);
        end else begin
            if (r_cnt > LIM) r_splat <= 1'b1;
            r_cnt <= '0;
        end
    end

    assign splat = r_splat;
endmodule

// File: rtl/lemming_dig_scheduler.sv
// Round-robin shovel arbiter with a refillable token budget.
// Issues one-cycle dig pulses and tracks lemming splats.
module lemming_dig_scheduler
    import lemming_ctrl_pkg::*;
#(
    parameter int N           = 4,
    parameter int DIG_BUDGET  = 8,
    parameter int SPLAT_LIMIT = SPLAT_LIMIT_DEF
) (
    input  logic                    clk,
    input  logic                    areset_n,
    lemming_dig_scheduler_if.slave  io_bus
);
    localparam int OW = $clog2(N);
    localparam int TW = $clog2(DIG_BUDGET + 1);
    localparam logic [TW-1:0] BUDGET = TW'(DIG_BUDGET);

    dig_state_e  r_state, w_state_nxt;
    logic [OW-1:0] r_owner, w_owner_nxt;
    logic [OW-1:0] r_rr_ptr, w_ptr_nxt;
    logic [TW-1:0] r_tokens, w_tokens_nxt;
    logic [N-1:0]  w_splat, w_elig;
    rr_pick_t      w_pick;
    logic          w_grant, w_refund;

    assign w_elig = io_bus.req & io_bus.walking & ~w_splat;
    assign w_pick = rr_pick(16'(w_elig), 4'(r_rr_ptr), N);

    // Next-state, owner latch and round-robin pointer advance.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_rr_ptr;
        w_grant     = 1'b0;
        w_refund    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_tokens != '0 && w_pick.valid) begin
                    w_grant     = 1'b1;
                    w_owner_nxt = OW'(w_pick.idx);
                    w_state_nxt = GRANT;
                end
            end
            GRANT: w_state_nxt = WAIT;
            WAIT: begin
                if (io_bus.digging[r_owner]) begin
                    w_state_nxt = DIGGING;
                end else begin
                    w_refund    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            DIGGING: begin
                if (!io_bus.digging[r_owner]) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = (r_owner == OW'(N - 1)) ?
                                  '0 : r_owner + OW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Token budget: refill wins, but a same-cycle grant still costs one.
    always_comb begin
        w_tokens_nxt = r_tokens;
        if (io_bus.refill) begin
            w_tokens_nxt = w_grant ? BUDGET - TW'(1) : BUDGET;
        end else if (w_grant) begin
            w_tokens_nxt = r_tokens - TW'(1);
        end else if (w_refund && r_tokens != BUDGET) begin
            w_tokens_nxt = r_tokens + TW'(1);
        end
    end

    // Scheduler state registers.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state  <= IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_tokens <= BUDGET;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_ptr_nxt;
            r_tokens <= w_tokens_nxt;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_fall
        lemming_fall_monitor #(
            .SPLAT_LIMIT(SPLAT_LIMIT)
        ) u_fall (
            .clk      (clk),
            .areset_n (areset_n),
            .aaah     (io_bus.aaah[i]),
            .splat    (w_splat[i])
        );
    end

    assign io_bus.dig    = (r_state == GRANT) ? (N'(1) << r_owner) : '0;
    assign io_bus.owner  = r_owner;
    assign io_bus.busy   = (r_state != IDLE);
    assign io_bus.tokens = r_tokens;
    assign io_bus.splat  = w_splat;
endmodule

// File: tb/tb_lemming_dig_scheduler.sv
// Directed bench for the lemming dig scheduler.
// Main instance uses budget 8, a second uses budget 2.
module tb_lemming_dig_scheduler;
    logic clk = 1'b0;
    logic areset_n = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    lemming_dig_scheduler_if #(.N(4), .DIG_BUDGET(8)) bus_a ();
    lemming_dig_scheduler_if #(.N(4), .DIG_BUDGET(2)) bus_b ();

    lemming_dig_scheduler #(
        .N(4), .DIG_BUDGET(8), .SPLAT_LIMIT(20)
    ) u_dut (
        .clk      (clk),
        .areset_n (areset_n),
        .io_bus   (bus_a)
    );

    lemming_dig_scheduler #(
        .N(4), .DIG_BUDGET(2), .SPLAT_LIMIT(20)
    ) u_dut_b (
        .clk      (clk),
        .areset_n (areset_n),
        .io_bus   (bus_b)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // From IDLE with lemming exp eligible: grant, 3-cycle dig, back to IDLE.
    task automatic grant_a(input int exp, input int tok);
        step(1);
        chk($sformatf("a_dig_%0d", exp), 32'(bus_a.dig), 32'(1 << exp));
        chk($sformatf("a_owner_%0d", exp), 32'(bus_a.owner), 32'(exp));
        chk($sformatf("a_tok_%0d", exp), 32'(bus_a.tokens), 32'(tok));
        bus_a.digging = 4'(1 << exp);
        step(1);
        chk("a_dig_one_cycle", 32'(bus_a.dig), 32'h0);
        step(1);
        chk("a_busy_digging", 32'(bus_a.busy), 32'h1);
        step(2);
        bus_a.digging = 4'h0;
        step(1);
        chk("a_idle_after_dig", 32'(bus_a.busy), 32'h0);
        chk("a_no_early_dig", 32'(bus_a.dig), 32'h0);
    endtask

    task automatic grant_b(input int exp, input int tok);
        step(1);
        chk($sformatf("b_dig_%0d", exp), 32'(bus_b.dig), 32'(1 << exp));
        chk($sformatf("b_tok_%0d", exp), 32'(bus_b.tokens), 32'(tok));
        bus_b.digging = 4'(1 << exp);
        step(2);
        bus_b.digging = 4'h0;
        step(1);
        chk("b_idle_after_dig", 32'(bus_b.busy), 32'h0);
    endtask

    initial begin
        bus_a.req = '0; bus_a.refill = 1'b0; bus_a.walking = '0;
        bus_a.digging = '0; bus_a.aaah = '0;
        bus_b.req = '0; bus_b.refill = 1'b0; bus_b.walking = '0;
        bus_b.digging = '0; bus_b.aaah = '0;

        step(2);
        chk("rst_dig", 32'(bus_a.dig), 32'h0);
        chk("rst_owner", 32'(bus_a.owner), 32'h0);
        chk("rst_busy", 32'(bus_a.busy), 32'h0);
        chk("rst_tokens", 32'(bus_a.tokens), 32'd8);
        chk("rst_splat", 32'(bus_a.splat), 32'h0);
        chk("rst_tokens_b", 32'(bus_b.tokens), 32'd2);
        areset_n = 1'b1;
        step(1);

        // single grant to lemming 0
        bus_a.req = 4'b0001; bus_a.walking = 4'b0001;
        grant_a(0, 7);
        bus_a.req = 4'b0000;

        // round robin, pointer now at 1
        step(1);
        bus_a.req = 4'b1111; bus_a.walking = 4'b1111;
        grant_a(1, 6);
        grant_a(2, 5);
        grant_a(3, 4);
        grant_a(0, 3);
        bus_a.req = 4'b0000;
        step(1);

        // rejected dig: lemming 1 falls before digging
        bus_a.req = 4'b0010; bus_a.walking = 4'b0010;
        step(1);
        chk("rej_dig", 32'(bus_a.dig), 32'b0010);
        chk("rej_tok_charged", 32'(bus_a.tokens), 32'd2);
        bus_a.walking = 4'b0000; bus_a.aaah = 4'b0010;
        step(1);
        chk("rej_wait_busy", 32'(bus_a.busy), 32'h1);
        step(1);
        chk("rej_idle", 32'(bus_a.busy), 32'h0);
        chk("rej_refund", 32'(bus_a.tokens), 32'd3);
        bus_a.aaah = 4'b0000; bus_a.walking = 4'b0010;
        grant_a(1, 2);
        bus_a.req = 4'b0000;
        step(1);

        // refill with grant, then refill during GRANT and refund saturating
        bus_a.req = 4'b0100; bus_a.walking = 4'b0100; bus_a.refill = 1'b1;
        step(1);
        chk("rfg_dig", 32'(bus_a.dig), 32'b0100);
        chk("rfg_tokens", 32'(bus_a.tokens), 32'd7);
        bus_a.req = 4'b0000;
        step(1);
        chk("rf_alone_tokens", 32'(bus_a.tokens), 32'd8);
        bus_a.refill = 1'b0;
        step(1);
        chk("refund_sat_busy", 32'(bus_a.busy), 32'h0);
        chk("refund_sat_tokens", 32'(bus_a.tokens), 32'd8);

        // budget exhaustion on the budget-2 instance
        bus_b.req = 4'b0011; bus_b.walking = 4'b0011;
        grant_b(0, 1);
        grant_b(1, 0);
        step(1);
        chk("b_stall_busy", 32'(bus_b.busy), 32'h0);
        chk("b_stall_tokens", 32'(bus_b.tokens), 32'd0);
        step(2);
        chk("b_stall_dig", 32'(bus_b.dig), 32'h0);
        chk("b_stall_busy2", 32'(bus_b.busy), 32'h0);
        bus_b.refill = 1'b1;
        step(1);
        bus_b.refill = 1'b0;
        chk("b_refill_tokens", 32'(bus_b.tokens), 32'd2);
        chk("b_refill_idle", 32'(bus_b.busy), 32'h0);
        step(1);
        chk("b_regrant_dig", 32'(bus_b.dig), 32'b0001);
        chk("b_regrant_tokens", 32'(bus_b.tokens), 32'd1);
        bus_b.req = 4'b0000;
        step(3);

        // 21-cycle fall splats lemming 2
        bus_a.aaah = 4'b0100;
        step(21);
        bus_a.aaah = 4'b0000;
        chk("splat_not_yet", 32'(bus_a.splat), 32'h0);
        step(1);
        chk("splat2_set", 32'(bus_a.splat), 32'b0100);

        // 20-cycle fall is survivable
        bus_a.aaah = 4'b1000;
        step(20);
        bus_a.aaah = 4'b0000;
        step(1);
        chk("splat3_clear", 32'(bus_a.splat), 32'b0100);

        // splatted lemming 2 skipped even though pointer is at 2
        bus_a.req = 4'b1100; bus_a.walking = 4'b1100;
        step(1);
        chk("skip_dig", 32'(bus_a.dig), 32'b1000);
        chk("skip_owner", 32'(bus_a.owner), 32'd3);
        chk("skip_tokens", 32'(bus_a.tokens), 32'd7);
        bus_a.req = 4'b0100;
        step(2);
        chk("skip_refund", 32'(bus_a.tokens), 32'd8);
        step(1);
        chk("dead_busy", 32'(bus_a.busy), 32'h0);
        step(2);
        chk("dead_dig", 32'(bus_a.dig), 32'h0);
        bus_a.req = 4'b0000;

        // async reset during DIGGING
        bus_a.req = 4'b0010; bus_a.walking = 4'b0010;
        step(1);
        chk("pre_rst_dig", 32'(bus_a.dig), 32'b0010);
        chk("pre_rst_tokens", 32'(bus_a.tokens), 32'd7);
        bus_a.digging = 4'b0010; bus_a.req = 4'b0000;
        step(2);
        chk("pre_rst_busy", 32'(bus_a.busy), 32'h1);
        #2 areset_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus_a.busy), 32'h0);
        chk("arst_dig", 32'(bus_a.dig), 32'h0);
        chk("arst_owner", 32'(bus_a.owner), 32'h0);
        chk("arst_tokens", 32'(bus_a.tokens), 32'd8);
        chk("arst_splat", 32'(bus_a.splat), 32'h0);
        chk("arst_tokens_b", 32'(bus_b.tokens), 32'd2);
        bus_a.digging = 4'b0000; bus_a.walking = 4'b0000;
        step(2);
        areset_n = 1'b1;
        step(2);
        chk("post_rst_dig", 32'(bus_a.dig), 32'h0);
        chk("post_rst_busy", 32'(bus_a.busy), 32'h0);
        chk("post_rst_tokens", 32'(bus_a.tokens), 32'd8);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
